// File: rtl/mem_arbiter_pkg.sv
// Shared types and helpers for the three-client memory arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    WDATA,
    RDATA
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_I_RD,
    OWN_D_RD,
    OWN_D_WR
  } owner_t;

  // Bit positions within the one-hot winner vector.
  localparam int WIN_I_RD = 0;
  localparam int WIN_D_RD = 1;
  localparam int WIN_D_WR = 2;

  // Address bits cleared to align a burst of 32-bit words.
  function automatic int align_bits(input int burst_len);
    return $clog2(burst_len) + 2;
  endfunction

endpackage

// File: rtl/mem_arb_select.sv
// Fixed-priority request picker with a saturating guard that lets a starved
// instruction fetch win after STARVE_LIMIT consecutive data-side grants.
module mem_arb_select
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_rd_req,
  input  logic       d_rd_req,
  input  logic       d_wr_req,
  input  logic       grant,
  output logic [2:0] winner
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt;
  logic             starved;

  assign starved = i_rd_req && (starve_cnt == CNT_MAX);

  // NOTE: winner gets a default before the priority chain so no path leaves
  // it unassigned; a missing default here would infer a latch.
  always_comb begin
    winner = '0;
    if (starved)       winner[WIN_I_RD] = 1'b1;
    else if (d_wr_req) winner[WIN_D_WR] = 1'b1;
    else if (d_rd_req) winner[WIN_D_RD] = 1'b1;
    else if (i_rd_req) winner[WIN_I_RD] = 1'b1;
  end

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (!i_rd_req || (grant && winner[WIN_I_RD])) begin
      starve_cnt <= '0;
    end else if (grant && (winner[WIN_D_RD] || winner[WIN_D_WR]) &&
                 (starve_cnt != CNT_MAX)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises i-cache reads, d-cache reads and d-cache writes onto a single
// burst memory port and routes read beats back to the owning cache.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 26,
  parameter int DATA_W       = 32,
  parameter int BURST_LEN    = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_rd_req,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic              i_rd_gnt,
  output logic              i_rd_valid,
  input  logic              d_rd_req,
  input  logic [ADDR_W-1:0] d_rd_addr,
  output logic              d_rd_gnt,
  output logic              d_rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              d_wr_req,
  input  logic [ADDR_W-1:0] d_wr_addr,
  input  logic [DATA_W-1:0] d_wr_data,
  output logic              d_wr_gnt,
  output logic              d_wr_ack,
  output logic              m_cmd_valid,
  input  logic              m_cmd_ready,
  output logic              m_cmd_write,
  output logic [ADDR_W-1:0] m_cmd_addr,
  output logic              m_wr_valid,
  output logic [DATA_W-1:0] m_wr_data,
  input  logic              m_wr_ready,
  input  logic              m_rd_valid,
  input  logic [DATA_W-1:0] m_rd_data
);

  localparam int BEAT_W  = $clog2(BURST_LEN);
  localparam int ALIGN_W = align_bits(BURST_LEN);
  localparam logic [ADDR_W-1:0] ALIGN_MASK =
    {{(ADDR_W-ALIGN_W){1'b1}}, {ALIGN_W{1'b0}}};
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

  state_t            state_q, state_d;
  owner_t            owner_q, win_owner;
  logic [ADDR_W-1:0] addr_q, win_addr;
  logic [BEAT_W-1:0] beat_cnt;
  logic [2:0]        winner;
  logic              grant;
  logic              beat_last;

  assign grant     = (state_q == IDLE) && (winner != 3'b000);
  assign beat_last = (beat_cnt == LAST_BEAT);

  mem_arb_select #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_sel (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_rd_req (i_rd_req),
    .d_rd_req (d_rd_req),
    .d_wr_req (d_wr_req),
    .grant    (grant),
    .winner   (winner)
  );

  always_comb begin
    win_owner = OWN_NONE;
    win_addr  = '0;
    if (winner[WIN_D_WR]) begin
      win_owner = OWN_D_WR;
      win_addr  = d_wr_addr;
    end else if (winner[WIN_D_RD]) begin
      win_owner = OWN_D_RD;
      win_addr  = d_rd_addr;
    end else if (winner[WIN_I_RD]) begin
      win_owner = OWN_I_RD;
      win_addr  = i_rd_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    m_cmd_valid = 1'b0;
    m_wr_valid  = 1'b0;
    m_wr_data   = '0;
    d_wr_ack    = 1'b0;
    unique case (state_q)
      IDLE: if (grant) state_d = CMD;
      CMD: begin
        m_cmd_valid = 1'b1;
        if (m_cmd_ready) state_d = (owner_q == OWN_D_WR) ? WDATA : RDATA;
      end
      WDATA: begin
        m_wr_valid = 1'b1;
        m_wr_data  = d_wr_data;
        d_wr_ack   = m_wr_ready;
        if (m_wr_ready && beat_last) state_d = IDLE;
      end
      RDATA: if (m_rd_valid && beat_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign m_cmd_addr  = addr_q;
  assign m_cmd_write = (owner_q == OWN_D_WR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q    <= OWN_NONE;
      addr_q     <= '0;
      beat_cnt   <= '0;
      i_rd_gnt   <= 1'b0;
      d_rd_gnt   <= 1'b0;
      d_wr_gnt   <= 1'b0;
      i_rd_valid <= 1'b0;
      d_rd_valid <= 1'b0;
      rd_data    <= '0;
    end else begin
      i_rd_gnt   <= grant && winner[WIN_I_RD];
      d_rd_gnt   <= grant && winner[WIN_D_RD];
      d_wr_gnt   <= grant && winner[WIN_D_WR];
      i_rd_valid <= 1'b0;
      d_rd_valid <= 1'b0;
      if (grant) begin
        owner_q <= win_owner;
        addr_q  <= win_addr & ALIGN_MASK;
      end
      if (state_q == CMD) beat_cnt <= '0;
      // The terminal beat leaves the counter alone; CMD re-zeroes it.
      if (((state_q == WDATA) && m_wr_ready) || ((state_q == RDATA) && m_rd_valid)) begin
        if (!beat_last) beat_cnt <= beat_cnt + 1'b1;
      end
      if ((state_q == RDATA) && m_rd_valid) begin
        rd_data    <= m_rd_data;
        i_rd_valid <= (owner_q == OWN_I_RD);
        d_rd_valid <= (owner_q == OWN_D_RD);
      end
    end
  end

  // Simulation-only check: memory must not return beats unless a read is open.
  a_no_stray_rd_beat: assert property (@(posedge clk) disable iff (!rst_n)
    m_rd_valid |-> (state_q == RDATA));

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with hand-computed expectations.
module tb_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        i_rd_req;
  logic [25:0] i_rd_addr;
  logic        i_rd_gnt;
  logic        i_rd_valid;
  logic        d_rd_req;
  logic [25:0] d_rd_addr;
  logic        d_rd_gnt;
  logic        d_rd_valid;
  logic [31:0] rd_data;
  logic        d_wr_req;
  logic [25:0] d_wr_addr;
  logic [31:0] d_wr_data;
  logic        d_wr_gnt;
  logic        d_wr_ack;
  logic        m_cmd_valid;
  logic        m_cmd_ready;
  logic        m_cmd_write;
  logic [25:0] m_cmd_addr;
  logic        m_wr_valid;
  logic [31:0] m_wr_data;
  logic        m_wr_ready;
  logic        m_rd_valid;
  logic [31:0] m_rd_data;

  int checks = 0;
  int errors = 0;

  logic [5:0]  wr_pat = 6'b110101;
  logic [31:0] wdat [4] = '{32'h11, 32'h22, 32'h33, 32'h44};

  mem_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_rd_req    (i_rd_req),
    .i_rd_addr   (i_rd_addr),
    .i_rd_gnt    (i_rd_gnt),
    .i_rd_valid  (i_rd_valid),
    .d_rd_req    (d_rd_req),
    .d_rd_addr   (d_rd_addr),
    .d_rd_gnt    (d_rd_gnt),
    .d_rd_valid  (d_rd_valid),
    .rd_data     (rd_data),
    .d_wr_req    (d_wr_req),
    .d_wr_addr   (d_wr_addr),
    .d_wr_data   (d_wr_data),
    .d_wr_gnt    (d_wr_gnt),
    .d_wr_ack    (d_wr_ack),
    .m_cmd_valid (m_cmd_valid),
    .m_cmd_ready (m_cmd_ready),
    .m_cmd_write (m_cmd_write),
    .m_cmd_addr  (m_cmd_addr),
    .m_wr_valid  (m_wr_valid),
    .m_wr_data   (m_wr_data),
    .m_wr_ready  (m_wr_ready),
    .m_rd_valid  (m_rd_valid),
    .m_rd_data   (m_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic finish_read(input logic [31:0] base);
    m_cmd_ready = 1'b1;
    tick();
    m_cmd_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      m_rd_valid = 1'b1;
      m_rd_data  = base + 32'(k);
      tick();
    end
    m_rd_valid = 1'b0;
  endtask

  task automatic finish_write();
    m_cmd_ready = 1'b1;
    tick();
    m_cmd_ready = 1'b0;
    m_wr_ready  = 1'b1;
    repeat (4) tick();
    m_wr_ready  = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    rst_n = 1'b0;
    i_rd_req = 0; i_rd_addr = '0; d_rd_req = 0; d_rd_addr = '0;
    d_wr_req = 0; d_wr_addr = '0; d_wr_data = 32'hDEAD_BEEF;
    m_cmd_ready = 0; m_wr_ready = 0; m_rd_valid = 0; m_rd_data = '0;
    #3;
    v = {i_rd_gnt, i_rd_valid, d_rd_gnt, d_rd_valid, d_wr_gnt, d_wr_ack,
         m_cmd_valid, m_cmd_write, m_wr_valid, 23'(m_cmd_addr | 26'(rd_data) | 26'(m_wr_data))};
    checks++;
    if (v !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0", v);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_i_rd_single();
    i_rd_req = 1'b1; i_rd_addr = 26'h000104;
    tick();
    checks++;
    if ({i_rd_gnt, d_rd_gnt, d_wr_gnt, m_cmd_valid, m_cmd_write} !== 5'b10010) begin
      errors++;
      $display("FAIL i_rd_grant: gnt i/d/w,cmd_valid,write got %b want 10010",
               {i_rd_gnt, d_rd_gnt, d_wr_gnt, m_cmd_valid, m_cmd_write});
    end
    checks++;
    if (m_cmd_addr !== 26'h000100) begin
      errors++;
      $display("FAIL i_rd_addr_align: got %h want 000100", m_cmd_addr);
    end
    i_rd_req = 1'b0;
    m_cmd_ready = 1'b1;
    tick();
    m_cmd_ready = 1'b0;
    checks++;
    if ({i_rd_gnt, m_cmd_valid} !== 2'b00) begin
      errors++;
      $display("FAIL i_rd_cmd_accept: gnt,cmd_valid got %b want 00", {i_rd_gnt, m_cmd_valid});
    end
    for (int k = 0; k < 4; k++) begin
      m_rd_valid = 1'b1;
      m_rd_data  = 32'hA0 + 32'(k);
      tick();
      checks++;
      if ({i_rd_valid, d_rd_valid} !== 2'b10 || rd_data !== 32'hA0 + 32'(k)) begin
        errors++;
        $display("FAIL i_rd_beat%0d: i/d valid %b data %h want 10 %h",
                 k, {i_rd_valid, d_rd_valid}, rd_data, 32'hA0 + 32'(k));
      end
    end
    m_rd_valid = 1'b0;
    tick();
    checks++;
    if ({i_rd_valid, d_rd_valid} !== 2'b00) begin
      errors++;
      $display("FAIL i_rd_after_burst: i/d valid %b want 00", {i_rd_valid, d_rd_valid});
    end
  endtask

  task automatic test_priority();
    d_wr_req = 1'b1; d_wr_addr = 26'h200;
    d_rd_req = 1'b1; d_rd_addr = 26'h300;
    i_rd_req = 1'b1; i_rd_addr = 26'h400;
    tick();
    checks++;
    if ({d_wr_gnt, d_rd_gnt, i_rd_gnt, m_cmd_write} !== 4'b1001 || m_cmd_addr !== 26'h200) begin
      errors++;
      $display("FAIL prio_first_wr: gnt w/d/i,write %b addr %h want 1001 200",
               {d_wr_gnt, d_rd_gnt, i_rd_gnt, m_cmd_write}, m_cmd_addr);
    end
    d_wr_req = 1'b0;
    d_wr_data = 32'h5555_0000;
    finish_write();
    checks++;
    if ({d_wr_gnt, d_rd_gnt, i_rd_gnt, m_cmd_valid, m_wr_valid} !== 5'b00000) begin
      errors++;
      $display("FAIL prio_idle_gap1: gnts,cmd,wr %b want 00000",
               {d_wr_gnt, d_rd_gnt, i_rd_gnt, m_cmd_valid, m_wr_valid});
    end
    tick();
    checks++;
    if ({d_wr_gnt, d_rd_gnt, i_rd_gnt, m_cmd_write} !== 4'b0100 || m_cmd_addr !== 26'h300) begin
      errors++;
      $display("FAIL prio_second_rd: gnt w/d/i,write %b addr %h want 0100 300",
               {d_wr_gnt, d_rd_gnt, i_rd_gnt, m_cmd_write}, m_cmd_addr);
    end
    d_rd_req = 1'b0;
    finish_read(32'hB0);
    checks++;
    if ({d_rd_valid, i_rd_valid, i_rd_gnt} !== 3'b100 || rd_data !== 32'hB3) begin
      errors++;
      $display("FAIL prio_d_rd_last: d/i valid,i_gnt %b data %h want 100 b3",
               {d_rd_valid, i_rd_valid, i_rd_gnt}, rd_data);
    end
    tick();
    checks++;
    if ({d_wr_gnt, d_rd_gnt, i_rd_gnt} !== 3'b001 || m_cmd_addr !== 26'h400) begin
      errors++;
      $display("FAIL prio_third_i_rd: gnt w/d/i %b addr %h want 001 400",
               {d_wr_gnt, d_rd_gnt, i_rd_gnt}, m_cmd_addr);
    end
    i_rd_req = 1'b0;
    finish_read(32'hC0);
    tick();
  endtask

  task automatic test_write_burst();
    int wi;
    int acks;
    wi = 0;
    acks = 0;
    d_wr_req = 1'b1; d_wr_addr = 26'h50C;
    tick();
    checks++;
    if ({d_wr_gnt, m_cmd_write} !== 2'b11 || m_cmd_addr !== 26'h500) begin
      errors++;
      $display("FAIL wr_grant: gnt,write %b addr %h want 11 500", {d_wr_gnt, m_cmd_write}, m_cmd_addr);
    end
    d_wr_req = 1'b0;
    m_cmd_ready = 1'b1;
    tick();
    m_cmd_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      m_wr_ready = wr_pat[c];
      d_wr_data  = wdat[wi];
      #1;
      checks++;
      if ({m_wr_valid, d_wr_ack} !== {1'b1, wr_pat[c]} || m_wr_data !== wdat[wi]) begin
        errors++;
        $display("FAIL wr_beat_c%0d: valid,ack %b data %h want %b %h",
                 c, {m_wr_valid, d_wr_ack}, m_wr_data, {1'b1, wr_pat[c]}, wdat[wi]);
      end
      if (d_wr_ack) acks++;
      tick();
      if (wr_pat[c]) wi++;
    end
    m_wr_ready = 1'b0;
    #1;
    checks++;
    if (acks !== 4 || {m_wr_valid, d_wr_ack, m_cmd_valid} !== 3'b000) begin
      errors++;
      $display("FAIL wr_done: acks %0d valid,ack,cmd %b want 4 000",
               acks, {m_wr_valid, d_wr_ack, m_cmd_valid});
    end
    tick();
  endtask

  task automatic test_starvation();
    d_rd_req = 1'b1; d_rd_addr = 26'h800;
    i_rd_req = 1'b1; i_rd_addr = 26'h900;
    for (int g = 0; g < 5; g++) begin
      tick();
      checks++;
      if ({d_rd_gnt, i_rd_gnt} !== ((g < 4) ? 2'b10 : 2'b01)) begin
        errors++;
        $display("FAIL starve_grant%0d: d/i gnt %b want %b",
                 g, {d_rd_gnt, i_rd_gnt}, (g < 4) ? 2'b10 : 2'b01);
      end
      if (g == 3) begin
        checks++;
        if (dut.u_sel.starve_cnt !== 3'd4) begin
          errors++;
          $display("FAIL starve_cnt_sat: got %0d want 4", dut.u_sel.starve_cnt);
        end
      end
      if (g == 4) begin
        d_rd_req = 1'b0;
        i_rd_req = 1'b0;
        checks++;
        if (dut.u_sel.starve_cnt !== 3'd0) begin
          errors++;
          $display("FAIL starve_cnt_clear: got %0d want 0", dut.u_sel.starve_cnt);
        end
      end
      finish_read(32'hE0);
    end
    tick();
  endtask

  task automatic test_cmd_stall();
    d_rd_req = 1'b1; d_rd_addr = 26'h3FC;
    tick();
    checks++;
    if (d_rd_gnt !== 1'b1) begin
      errors++;
      $display("FAIL stall_grant: d_rd_gnt %b want 1", d_rd_gnt);
    end
    d_rd_req = 1'b0;
    for (int c = 0; c < 10; c++) begin
      checks++;
      if ({m_cmd_valid, m_cmd_write} !== 2'b10 || m_cmd_addr !== 26'h3F0) begin
        errors++;
        $display("FAIL stall_hold_c%0d: valid,write %b addr %h want 10 3f0",
                 c, {m_cmd_valid, m_cmd_write}, m_cmd_addr);
      end
      tick();
    end
    m_cmd_ready = 1'b1;
    #1;
    checks++;
    if (m_cmd_valid !== 1'b1) begin
      errors++;
      $display("FAIL stall_cycle11_valid: got %b want 1", m_cmd_valid);
    end
    tick();
    m_cmd_ready = 1'b0;
    checks++;
    if (m_cmd_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_accepted: m_cmd_valid %b want 0", m_cmd_valid);
    end
    for (int k = 0; k < 4; k++) begin
      m_rd_valid = 1'b1;
      m_rd_data  = 32'h70 + 32'(k);
      tick();
    end
    m_rd_valid = 1'b0;
    checks++;
    if ({d_rd_valid, i_rd_valid} !== 2'b10 || rd_data !== 32'h73) begin
      errors++;
      $display("FAIL stall_last_beat: d/i valid %b data %h want 10 73",
               {d_rd_valid, i_rd_valid}, rd_data);
    end
    tick();
  endtask

  task automatic test_reset_mid_burst();
    logic [31:0] v;
    i_rd_req = 1'b1; i_rd_addr = 26'h608;
    tick();
    i_rd_req = 1'b0;
    m_cmd_ready = 1'b1;
    tick();
    m_cmd_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      m_rd_valid = 1'b1;
      m_rd_data  = 32'hC0 + 32'(k);
      tick();
    end
    checks++;
    if (i_rd_valid !== 1'b1 || rd_data !== 32'hC1) begin
      errors++;
      $display("FAIL rst_pre_beat1: valid %b data %h want 1 c1", i_rd_valid, rd_data);
    end
    m_rd_valid = 1'b1;
    m_rd_data  = 32'hC2;
    #2;
    rst_n = 1'b0;
    m_rd_valid = 1'b0;
    #1;
    v = {i_rd_gnt, i_rd_valid, d_rd_gnt, d_rd_valid, d_wr_gnt, d_wr_ack,
         m_cmd_valid, m_cmd_write, m_wr_valid, 23'(m_cmd_addr | 26'(rd_data) | 26'(m_wr_data))};
    checks++;
    if (v !== 32'h0) begin
      errors++;
      $display("FAIL rst_async_clear: got %h want 0", v);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    i_rd_req = 1'b1; i_rd_addr = 26'h704;
    tick();
    checks++;
    if ({i_rd_gnt, m_cmd_valid, m_cmd_write} !== 3'b110 || m_cmd_addr !== 26'h700) begin
      errors++;
      $display("FAIL rst_recover_grant: gnt,valid,write %b addr %h want 110 700",
               {i_rd_gnt, m_cmd_valid, m_cmd_write}, m_cmd_addr);
    end
    i_rd_req = 1'b0;
    m_cmd_ready = 1'b1;
    tick();
    m_cmd_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      m_rd_valid = 1'b1;
      m_rd_data  = 32'hD0 + 32'(k);
      tick();
      checks++;
      if ({i_rd_valid, d_rd_valid} !== 2'b10 || rd_data !== 32'hD0 + 32'(k)) begin
        errors++;
        $display("FAIL rst_recover_beat%0d: i/d valid %b data %h want 10 %h",
                 k, {i_rd_valid, d_rd_valid}, rd_data, 32'hD0 + 32'(k));
      end
    end
    m_rd_valid = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_i_rd_single();
    test_priority();
    test_write_burst();
    test_starvation();
    test_cmd_stall();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name:
mem_arbiter

Overview:
Sits directly downstream of the core's three memory request ports: instruction-cache line read, data-cache line read and data-cache line write. Serialises them onto one burst-capable external memory port. Routes read beats back to the owning cache and streams write beats from the data cache. Fixed priority with a starvation guard keeps instruction fetch alive.

Parameters:
ADDR_W, 26, byte address width; all addresses are byte addresses.
DATA_W, 32, beat width.
BURST_LEN, 4, words per transaction (one cache line); power of two, at least 2.
STARVE_LIMIT, 4, consecutive data-side grants allowed while i_rd_req waits.

Ports:
clk  in  1  clock
rst_n  in  1  reset; one clock; reset is asynchronous and active-low
i_rd_req  in  1  i-cache line read request; held until i_rd_gnt
i_rd_addr  in  ADDR_W  i-cache read byte address
i_rd_gnt  out  1  one-cycle pulse: i-cache request accepted
i_rd_valid  out  1  rd_data holds an i-cache beat
d_rd_req  in  1  d-cache line read request; held until d_rd_gnt
d_rd_addr  in  ADDR_W  d-cache read byte address
d_rd_gnt  out  1  one-cycle pulse: d-cache read accepted
d_rd_valid  out  1  rd_data holds a d-cache beat
rd_data  out  DATA_W  read beat, shared by both read clients
d_wr_req  in  1  d-cache line write request; held until d_wr_gnt
d_wr_addr  in  ADDR_W  write byte address
d_wr_data  in  DATA_W  current write beat; advance on d_wr_ack
d_wr_gnt  out  1  one-cycle pulse: write accepted
d_wr_ack  out  1  current write beat consumed
m_cmd_valid  out  1  command valid
m_cmd_ready  in  1  memory accepts command
m_cmd_write  out  1  1 = write burst, 0 = read burst
m_cmd_addr  out  ADDR_W  burst-aligned byte address
m_wr_valid  out  1  write beat valid
m_wr_data  out  DATA_W  write beat (= d_wr_data)
m_wr_ready  in  1  memory consumes write beat
m_rd_valid  in  1  read beat valid; no backpressure
m_rd_data  in  DATA_W  read beat

Behaviour:
- States: IDLE, CMD, WDATA, RDATA. Reset enters IDLE immediately. All outputs, beat counter, starve counter and owner register go to 0. Any in-flight burst is abandoned.
- IDLE arbitration, sampled at edge N. Priority is d_wr > d_rd > i_rd, except when starve_cnt == STARVE_LIMIT and i_rd_req is high; then i_rd wins.
- The winner's gnt pulses in cycle N+1. Owner and address are registered, with the low log2(BURST_LEN)+2 bits cleared. The FSM moves to CMD.
- starve_cnt: increments on each d_rd or d_wr grant while i_rd_req=1. Clears on an i_rd grant or when i_rd_req=0. Saturates at STARVE_LIMIT.
- CMD: m_cmd_valid=1 with m_cmd_addr/m_cmd_write stable until m_cmd_ready. On ready, go to WDATA if writing, else RDATA; beat_cnt=0.
- WDATA: m_wr_valid=1 and m_wr_data=d_wr_data (combinational). On m_wr_ready, d_wr_ack=1 the same cycle and beat_cnt increments. The beat with beat_cnt==BURST_LEN-1 returns the FSM to IDLE.
- RDATA: each m_rd_valid registers m_rd_data to rd_data and pulses the owner's *_rd_valid one cycle later (1-cycle latency). Beats arrive in address order. Return to IDLE after BURST_LEN beats.
- IDLE is held at least one cycle between transactions, so there is no back-to-back grant. The bus is released before the last beat's rd_valid appears.
- A request still high after its gnt is treated as a new request. Clients drop req the cycle after gnt.
- m_rd_valid outside RDATA is ignored; the simulation-only assertion flags it. m_wr_ready outside WDATA is ignored.
- beat_cnt width is log2(BURST_LEN). Terminal beat detection uses equality, so the counter never wraps.

Decomposition:
- Package mem_arbiter_pkg: state enum {IDLE,CMD,WDATA,RDATA}, owner enum {OWN_NONE,OWN_I_RD,OWN_D_RD,OWN_D_WR}, and a helper for burst-align mask width.
- Sub-module mem_arb_select: priority pick plus saturating starve counter. It takes the three reqs and a grant strobe, and outputs a one-hot winner.

Test Plan:
- i_rd_req, addr 0x000104, alone -> i_rd_gnt at +1, m_cmd_addr=0x000100, m_cmd_write=0; beats 0xA0..0xA3 yield 4 i_rd_valid pulses with rd_data 0xA0..0xA3; d_rd_valid stays 0.
- All three reqs in the same cycle (0x200, 0x300, 0x400) -> grants in order d_wr(0x200), d_rd(0x300), i_rd(0x400), each separated by an IDLE cycle.
- Write burst of 0x11,0x22,0x33,0x44 with m_wr_ready=1,0,1,0,1,1 -> exactly 4 d_wr_ack pulses aligned with ready; memory receives 0x11..0x44 in order; then IDLE.
- d_rd_req held continuously with i_rd_req high -> 4 d_rd grants, then i_rd granted; starve_cnt back to 0.
- m_cmd_ready low for 10 cycles -> m_cmd_valid, m_cmd_addr and m_cmd_write stable throughout; accepted on the 11th cycle.
- rst_n dropped during RDATA beat 2 -> all outputs 0 asynchronously; after release, a new i_rd request completes normally.
